// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: control bit positions, FSM states
// and the beat-counter width helper.
package seq_alu_pkg;

  localparam int EX = 5;
  localparam int NX = 4;
  localparam int EY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-beat configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nbeats);
    if (nbeats <= 1) begin
      return 1;
    end else begin
      return $clog2(nbeats);
    end
  endfunction

endpackage

// File: rtl/alu_slice.sv
// One SLICE-bit beat of the ALU: operand conditioning, add/and, output invert.
// Purely combinational; the caller registers the carry between beats.
module alu_slice
  import seq_alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  input  logic [5:0]       ctrl,
  output logic [SLICE-1:0] res,
  output logic             cout
);

  logic [SLICE-1:0] inx_s;
  logic [SLICE-1:0] iny_s;
  logic [SLICE-1:0] argx_s;
  logic [SLICE-1:0] argy_s;
  logic [SLICE:0]   sum_s;
  logic [SLICE-1:0] fres_s;

  assign inx_s  = ctrl[EX] ? x : {SLICE{1'b0}};
  assign argx_s = ctrl[NX] ? ~inx_s : inx_s;
  assign iny_s  = ctrl[EY] ? y : {SLICE{1'b0}};
  assign argy_s = ctrl[NY] ? ~iny_s : iny_s;

  assign sum_s  = {1'b0, argx_s} + {1'b0, argy_s} + {{SLICE{1'b0}}, cin};

  // The carry is taken before the output inversion so it reflects the raw sum.
  assign fres_s = ctrl[F] ? sum_s[SLICE-1:0] : (argx_s & argy_s);
  assign cout   = ctrl[F] ? sum_s[SLICE] : 1'b0;
  assign res    = ctrl[NO] ? ~fres_s : fres_s;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: evaluates WIDTH bits SLICE bits per clock, LSB first,
// with a start/busy/done handshake and held result/flag registers.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [5:0]       C,
  input  logic             en_bar,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] bus,
  output logic             Z_flag,
  output logic             LT_flag,
  output logic             CO_flag
);

  localparam int NBEATS = WIDTH / SLICE;
  localparam int CW     = cnt_width(NBEATS);

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             zacc_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [5:0]       c_r;
  logic [WIDTH-1:0] val_r;
  logic             z_r;
  logic             lt_r;
  logic             co_r;

  logic             accept_s;
  logic             last_s;
  int               base_s;
  logic [SLICE-1:0] xs_s;
  logic [SLICE-1:0] ys_s;
  logic [SLICE-1:0] res_s;
  logic             cout_s;

  // A new op is taken whenever no op is running, including the DONE beat.
  assign accept_s = start && (state_r != RUN);
  assign last_s   = (cnt_r == CW'(NBEATS - 1));
  assign base_s   = int'(cnt_r) * SLICE;
  assign xs_s     = x_r[base_s +: SLICE];
  assign ys_s     = y_r[base_s +: SLICE];

  alu_slice #(.SLICE(SLICE)) u_slice (
    .x    (xs_s),
    .y    (ys_s),
    .cin  (carry_r),
    .ctrl (c_r),
    .res  (res_s),
    .cout (cout_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, per-beat datapath update and flag latch on the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      zacc_r  <= 1'b0;
      x_r     <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      c_r     <= 6'd0;
      val_r   <= {WIDTH{1'b0}};
      z_r     <= 1'b0;
      lt_r    <= 1'b0;
      co_r    <= 1'b0;
    end else if (accept_s) begin
      x_r     <= X;
      y_r     <= Y;
      c_r     <= C;
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      zacc_r  <= 1'b1;
    end else if (state_r == RUN) begin
      val_r[base_s +: SLICE] <= res_s;
      carry_r <= cout_s;
      zacc_r  <= zacc_r & (res_s == {SLICE{1'b0}});
      cnt_r   <= cnt_r + CW'(1);
      // The final slice holds the MSB, so LT comes straight from it.
      if (last_s) begin
        z_r  <= zacc_r & (res_s == {SLICE{1'b0}});
        lt_r <= res_s[SLICE-1];
        co_r <= cout_s;
      end
    end
  end

  assign busy    = (state_r == RUN);
  assign done    = (state_r == DONE);
  assign val     = val_r;
  assign Z_flag  = z_r;
  assign LT_flag = lt_r;
  assign CO_flag = co_r;
  assign bus     = en_bar ? {WIDTH{1'bz}} : val_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table, corner-case sequences and
// randomized ops against a whole-word reference model.
module tb_seq_alu;

  localparam int W = 16;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset, start, start1, en_bar;
  logic [W-1:0] X, Y;
  logic [5:0] C;
  logic busy, done, zf, ltf, cof;
  logic [W-1:0] val;
  wire  [W-1:0] bus;
  logic busy1, done1, zf1, ltf1, cof1;
  logic [W-1:0] val1;
  wire  [W-1:0] bus1;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(16), .SLICE(4)) u0 (
    .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y), .C(C), .en_bar(en_bar),
    .busy(busy), .done(done), .val(val), .bus(bus),
    .Z_flag(zf), .LT_flag(ltf), .CO_flag(cof));

  seq_alu #(.WIDTH(16), .SLICE(16)) u1 (
    .clk(clk), .reset(reset), .start(start1), .X(X), .Y(Y), .C(C), .en_bar(en_bar),
    .busy(busy1), .done(done1), .val(val1), .bus(bus1),
    .Z_flag(zf1), .LT_flag(ltf1), .CO_flag(cof1));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [15:0] v;
    logic        z;
    logic        lt;
    logic        co;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-word reference: returns {co, lt, z, val}.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] c);
    logic [15:0] ax, ay, r;
    logic [16:0] s;
    logic co;
    ax = c[5] ? x : 16'h0000;
    if (c[4]) ax = ~ax;
    ay = c[3] ? y : 16'h0000;
    if (c[2]) ay = ~ay;
    if (c[1]) begin
      s  = {1'b0, ax} + {1'b0, ay};
      r  = s[15:0];
      co = s[16];
    end else begin
      r  = ax & ay;
      co = 1'b0;
    end
    if (c[0]) r = ~r;
    return {co, r[15], (r == 16'h0000), r};
  endfunction

  // Issue one op and wait (bounded) for done; ends on the negedge where done is seen.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                        output int lat, output int bcnt);
    @(negedge clk);
    X = x; Y = y; C = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, bcnt, ndone, gap;
    logic [15:0] held;
    logic [18:0] m;
    logic [15:0] rx, ry;
    logic [5:0]  rc;

    vecs[0] = '{16'h1234, 16'h0FFF, 6'h2A, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 6'h3B, 16'hFFFE, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0001, 6'h2A, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'hF0F0, 16'h0FF0, 6'h28, 16'h00F0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'hABCD, 16'h1234, 6'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'hABCD, 16'h1234, 6'h01, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 6'h3F, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 6'h2A, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'h7FFF, 16'h0001, 6'h2A, 16'h8000, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; start1 = 1'b0; en_bar = 1'b1;
    X = 16'h0000; Y = 16'h0000; C = 6'h00;
    repeat (2) @(negedge clk);
    // Reset must win over a simultaneous start.
    start = 1'b1; X = 16'h1234; Y = 16'h0FFF; C = 6'h2A;
    @(negedge clk);
    start = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_val", val, 16'h0000);
    check("rst_flags", {zf, ltf, cof}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].c, lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, NB);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, NB);
      check($sformatf("vec%0d_val", i), val, vecs[i].v);
      check($sformatf("vec%0d_z", i), zf, vecs[i].z);
      check($sformatf("vec%0d_lt", i), ltf, vecs[i].lt);
      check($sformatf("vec%0d_co", i), cof, vecs[i].co);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
      check($sformatf("vec%0d_val_held", i), val, vecs[i].v);
    end

    // Start during RUN is ignored.
    @(negedge clk);
    X = 16'hF0F0; Y = 16'h0FF0; C = 6'h28; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    X = 16'h0000; Y = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    held = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        ndone++;
        held = val;
      end
      @(negedge clk);
    end
    check("ign_done_count", ndone, 1);
    check("ign_val", held, 16'h00F0);

    // Back-to-back ops with start held through DONE.
    X = 16'h1234; Y = 16'h0FFF; C = 6'h2A; start = 1'b1;
    @(negedge clk);
    X = 16'h0001; Y = 16'h0001;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_val", val, 16'h2233);
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (done !== 1'b1 && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, NB + 1);
    check("b2b_second_val", val, 16'h0002);

    // Reset mid-op after an op that left flags set.
    run_op(16'hFFFF, 16'h0001, 6'h2A, lat, bcnt);
    check("pre_rst_flags", {zf, cof}, 2'b11);
    @(negedge clk);
    X = 16'h1234; Y = 16'h0FFF; C = 6'h2A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_val", val, 16'h0000);
    check("midrst_flags", {zf, ltf, cof}, 3'b000);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // Bus enable: a non-zero result must not reach the bus while disabled.
    run_op(16'h1234, 16'h0FFF, 6'h2A, lat, bcnt);
    en_bar = 1'b1;
    #1;
    // A two-state simulator resolves an undriven net to zero.
    check("bus_hiz", ((bus === 16'hzzzz) || (bus === 16'h0000)), 1'b1);
    en_bar = 1'b0;
    #1;
    check("bus_drive", bus, 16'h2233);
    en_bar = 1'b1;

    // Single-beat configuration.
    @(negedge clk);
    X = 16'h1234; Y = 16'h0FFF; C = 6'h2A; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("s16_busy", busy1, 1'b1);
    check("s16_done_early", done1, 1'b0);
    @(negedge clk);
    check("s16_done", done1, 1'b1);
    check("s16_busy_off", busy1, 1'b0);
    check("s16_val", val1, 16'h2233);
    check("s16_flags", {zf1, ltf1, cof1}, 3'b000);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom_range(0, 63));
      run_op(rx, ry, rc, lat, bcnt);
      m = model(rx, ry, rc);
      check($sformatf("rnd%0d_lat x=%h y=%h c=%h", i, rx, ry, rc), lat, NB);
      check($sformatf("rnd%0d_val x=%h y=%h c=%h", i, rx, ry, rc), val, m[15:0]);
      check($sformatf("rnd%0d_flags x=%h y=%h c=%h", i, rx, ry, rc),
            {cof, ltf, zf}, m[18:16]);
      en_bar = 1'b0;
      #1;
      check($sformatf("rnd%0d_bus", i), bus, m[15:0]);
      en_bar = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
